soduku_checker: RTL and testbench

SODUKU_CHECKER -- requirements
Module: soduku_checker

---
 rtl/soduku_checker.sv | 165 ++++++++++++++++
 tb/tb_soduku_checker.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/soduku_checker.sv
// soduku_checker: checks a 9x9 sudoku board held on a BCD bus, one group
// (row, column or 3x3 square) per clock, and reports empty cells, conflicts
// and the first offending group.
//
// state | meaning
// IDLE  | waiting for start_in; results from the last check are held
// SCAN  | evaluating group g_q (rows 0-8, columns 9-17, squares 18-26)
// DONE  | last group evaluated; publish solved and pulse done on exit
module soduku_checker #(
    parameter int GRID_SIZE = 9
) (
    input  logic                             clk_in,
    input  logic                             reset_in,
    input  logic                             start_in,
    input  logic [4*GRID_SIZE*GRID_SIZE-1:0] board_in,
    output logic                             busy_out,
    output logic                             done_out,
    output logic                             solved_out,
    output logic                             has_empty_out,
    output logic                             conflict_out,
    output logic [4:0]                       bad_group_out
);

    localparam int         BOARD_W    = 4 * GRID_SIZE * GRID_SIZE;
    localparam logic [4:0] LAST_GROUP = 5'd26;
    localparam logic [4:0] NO_GROUP   = 5'd31;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t               state_q, state_d;
    logic [4:0]           g_q, g_d;
    logic [BOARD_W-1:0]   snap_q, snap_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 solved_q, solved_d;
    logic                 has_empty_q, has_empty_d;
    logic                 conflict_q, conflict_d;
    logic [4:0]           bad_group_q, bad_group_d;

    logic                 grp_empty;
    logic                 grp_conflict;
    logic [15:0]          seen;
    logic [8:0]           base;
    logic [3:0]           v;
    int                   r, c, k;

    // Evaluate the nine cells of the current group from the snapshot.
    always_comb begin
        grp_empty    = 1'b0;
        grp_conflict = 1'b0;
        seen         = '0;
        base         = '0;
        v            = '0;
        r            = 0;
        c            = 0;
        k            = 0;
        for (int i = 0; i < GRID_SIZE; i++) begin
            if (g_q < 5'd9) begin
                r = int'(g_q);
                c = i;
            end else if (g_q < 5'd18) begin
                r = i;
                c = int'(g_q) - 9;
            end else begin
                k = int'(g_q) - 18;
                r = 3 * (k / 3) + i / 3;
                c = 3 * (k % 3) + i % 3;
            end
            // Row 0 / column 0 sit in the most significant nibble.
            base = 9'(36 * (8 - r) + 4 * (8 - c));
            v    = snap_q[base +: 4];
            if (v == 4'd0) begin
                grp_empty = 1'b1;
            end else if (v > 4'd9) begin
                grp_conflict = 1'b1;
            end else begin
                if (seen[v]) grp_conflict = 1'b1;
                seen[v] = 1'b1;
            end
        end
    end

    // Next-state and result-update logic for the IDLE/SCAN/DONE sequencer.
    always_comb begin
        state_d     = state_q;
        g_d         = g_q;
        snap_d      = snap_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        solved_d    = solved_q;
        has_empty_d = has_empty_q;
        conflict_d  = conflict_q;
        bad_group_d = bad_group_q;
        unique case (state_q)
            IDLE: begin
                if (start_in) begin
                    snap_d      = board_in;
                    g_d         = '0;
                    busy_d      = 1'b1;
                    solved_d    = 1'b0;
                    has_empty_d = 1'b0;
                    conflict_d  = 1'b0;
                    bad_group_d = NO_GROUP;
                    state_d     = SCAN;
                end
            end
            SCAN: begin
                if (grp_empty) has_empty_d = 1'b1;
                if (grp_conflict) begin
                    conflict_d = 1'b1;
                    // Only the first conflicting group is reported.
                    if (!conflict_q) bad_group_d = g_q;
                end
                if (g_q == LAST_GROUP) begin
                    state_d = DONE;
                end else begin
                    g_d = g_q + 5'd1;
                end
            end
            DONE: begin
                done_d   = 1'b1;
                busy_d   = 1'b0;
                solved_d = !has_empty_q && !conflict_q;
                g_d      = '0;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and result registers with asynchronous reset.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state_q     <= IDLE;
            g_q         <= '0;
            snap_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            solved_q    <= 1'b0;
            has_empty_q <= 1'b0;
            conflict_q  <= 1'b0;
            bad_group_q <= NO_GROUP;
        end else begin
            state_q     <= state_d;
            g_q         <= g_d;
            snap_q      <= snap_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            solved_q    <= solved_d;
            has_empty_q <= has_empty_d;
            conflict_q  <= conflict_d;
            bad_group_q <= bad_group_d;
        end
    end

    assign busy_out      = busy_q;
    assign done_out      = done_q;
    assign solved_out    = solved_q;
    assign has_empty_out = has_empty_q;
    assign conflict_out  = conflict_q;
    assign bad_group_out = bad_group_q;

endmodule

// File: tb/tb_soduku_checker.sv
// tb_soduku_checker: self-checking bench for soduku_checker; expected results
// come from a board-level reference model that counts digits per group.
module tb_soduku_checker;

    logic         clk_in   = 1'b0;
    logic         reset_in = 1'b1;
    logic         start_in = 1'b0;
    logic [323:0] board_in = '0;
    logic         busy_out;
    logic         done_out;
    logic         solved_out;
    logic         has_empty_out;
    logic         conflict_out;
    logic [4:0]   bad_group_out;
    logic [7:0]   res;

    typedef int grid_t [9][9];

    grid_t sol;
    int    pass_cnt  = 0;
    int    total_cnt = 0;

    soduku_checker #(.GRID_SIZE(9)) dut (
        .clk_in        (clk_in),
        .reset_in      (reset_in),
        .start_in      (start_in),
        .board_in      (board_in),
        .busy_out      (busy_out),
        .done_out      (done_out),
        .solved_out    (solved_out),
        .has_empty_out (has_empty_out),
        .conflict_out  (conflict_out),
        .bad_group_out (bad_group_out)
    );

    // Result bundle: {solved, has_empty, conflict, bad_group}.
    assign res = {solved_out, has_empty_out, conflict_out, bad_group_out};

    always #5 clk_in = ~clk_in;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [323:0] pack(input grid_t g);
        logic [323:0] b;
        b = '0;
        for (int r = 0; r < 9; r++)
            for (int c = 0; c < 9; c++)
                b[36*(9-r)-4*c-4 +: 4] = 4'(g[r][c]);
        return b;
    endfunction

    function automatic bit in_group(input int grp, input int r, input int c);
        if (grp < 9)  return r == grp;
        if (grp < 18) return c == grp - 9;
        return (3 * (r / 3) + c / 3) == grp - 18;
    endfunction

    // Reference: count each value in each group, then apply the board rules.
    function automatic logic [7:0] model(input grid_t g);
        bit empty;
        bit conflict;
        bit hit;
        int bad;
        int cnt [16];
        empty    = 0;
        conflict = 0;
        bad      = 31;
        for (int grp = 0; grp < 27; grp++) begin
            for (int d = 0; d < 16; d++) cnt[d] = 0;
            for (int r = 0; r < 9; r++)
                for (int c = 0; c < 9; c++)
                    if (in_group(grp, r, c)) cnt[g[r][c]]++;
            hit = 0;
            for (int d = 1; d < 16; d++) begin
                if (d > 9 && cnt[d] > 0) hit = 1;
                if (d <= 9 && cnt[d] > 1) hit = 1;
            end
            if (cnt[0] > 0) empty = 1;
            if (hit && !conflict) bad = grp;
            if (hit) conflict = 1;
        end
        return {(!empty && !conflict), empty, conflict, 5'(bad)};
    endfunction

    task automatic do_start(input logic [323:0] b);
        board_in = b;
        start_in = 1'b1;
        @(posedge clk_in);
        #1;
        start_in = 1'b0;
    endtask

    // Counts edges since the accepting edge until done_out is seen (bounded).
    task automatic wait_done(input int elapsed, output int cycles);
        cycles = elapsed;
        while (cycles < 40) begin
            @(posedge clk_in);
            #1;
            cycles++;
            if (done_out) break;
        end
    endtask

    task automatic test_reset();
        reset_in = 1'b1;
        repeat (2) @(posedge clk_in);
        #1;
        total_cnt++;
        if (res !== {1'b0, 1'b0, 1'b0, 5'd31})
            $display("FAIL reset_results got %h want %h", res, {1'b0, 1'b0, 1'b0, 5'd31});
        else pass_cnt++;
        total_cnt++;
        if (busy_out !== 1'b0) $display("FAIL reset_busy got %b want 0", busy_out);
        else pass_cnt++;
        total_cnt++;
        if (done_out !== 1'b0) $display("FAIL reset_done got %b want 0", done_out);
        else pass_cnt++;
        reset_in = 1'b0;
    endtask

    task automatic test_solved();
        int cyc;
        logic [7:0] exp;
        exp = model(sol);
        do_start(pack(sol));
        total_cnt++;
        if (busy_out !== 1'b1) $display("FAIL solved_busy got %b want 1", busy_out);
        else pass_cnt++;
        wait_done(0, cyc);
        total_cnt++;
        if (cyc != 28) $display("FAIL solved_latency got %0d want 28", cyc);
        else pass_cnt++;
        total_cnt++;
        if (res !== 8'b1_0_0_11111) $display("FAIL solved_result got %h want %h", res, 8'b1_0_0_11111);
        else pass_cnt++;
        total_cnt++;
        if (res !== exp) $display("FAIL solved_model got %h want %h", res, exp);
        else pass_cnt++;
        total_cnt++;
        if (busy_out !== 1'b0) $display("FAIL solved_busy_drop got %b want 0", busy_out);
        else pass_cnt++;
        @(posedge clk_in);
        #1;
        total_cnt++;
        if (done_out !== 1'b0) $display("FAIL done_single_pulse got %b want 0", done_out);
        else pass_cnt++;
        board_in = '1;
        repeat (5) @(posedge clk_in);
        #1;
        total_cnt++;
        if (res !== exp) $display("FAIL result_hold got %h want %h", res, exp);
        else pass_cnt++;
    endtask

    task automatic test_corners();
        grid_t g;
        int cyc;
        logic [7:0] want [3];
        want[0] = {1'b0, 1'b1, 1'b0, 5'd31};
        want[1] = {1'b0, 1'b0, 1'b1, 5'd0};
        want[2] = {1'b0, 1'b0, 1'b1, 5'd4};
        for (int t = 0; t < 3; t++) begin
            g = sol;
            if (t == 0) g[0][0] = 0;
            if (t == 1) g[0][0] = 5;
            if (t == 2) g[4][4] = 10;
            do_start(pack(g));
            wait_done(0, cyc);
            total_cnt++;
            if (cyc != 28) $display("FAIL corner%0d_latency got %0d want 28", t, cyc);
            else pass_cnt++;
            total_cnt++;
            if (res !== want[t]) $display("FAIL corner%0d_result got %h want %h", t, res, want[t]);
            else pass_cnt++;
        end
    endtask

    task automatic test_random();
        grid_t g;
        int cyc;
        int n;
        logic [7:0] exp;
        for (int it = 0; it < 24; it++) begin
            g = sol;
            if (it % 6 == 5) begin
                for (int r = 0; r < 9; r++)
                    for (int c = 0; c < 9; c++)
                        g[r][c] = int'($urandom_range(0, 15));
            end else begin
                n = int'($urandom_range(0, 3));
                for (int m = 0; m < n; m++)
                    g[$urandom_range(0, 8)][$urandom_range(0, 8)] = int'($urandom_range(0, 15));
            end
            exp = model(g);
            do_start(pack(g));
            wait_done(0, cyc);
            total_cnt++;
            if (cyc != 28 || res !== exp)
                $display("FAIL random%0d got lat=%0d res=%h want lat=28 res=%h", it, cyc, res, exp);
            else pass_cnt++;
        end
    endtask

    task automatic test_ignore_start();
        grid_t g;
        int cyc;
        logic [7:0] exp;
        exp = model(sol);
        g = sol;
        g[2][3] = 0;
        g[7][7] = 12;
        do_start(pack(sol));
        repeat (9) @(posedge clk_in);
        #1;
        do_start(pack(g));
        wait_done(10, cyc);
        total_cnt++;
        if (cyc != 28) $display("FAIL ignore_latency got %0d want 28", cyc);
        else pass_cnt++;
        total_cnt++;
        if (res !== exp) $display("FAIL ignore_snapshot got %h want %h", res, exp);
        else pass_cnt++;
        @(posedge clk_in);
        #1;
        total_cnt++;
        if (busy_out !== 1'b0 || done_out !== 1'b0)
            $display("FAIL ignore_no_queue got busy=%b done=%b want 0 0", busy_out, done_out);
        else pass_cnt++;
    endtask

    task automatic test_reset_midscan();
        grid_t g;
        int cyc;
        bit saw;
        g = sol;
        g[8][8] = 0;
        do_start(pack(g));
        repeat (15) @(posedge clk_in);
        #2;
        reset_in = 1'b1;
        #1;
        total_cnt++;
        if (res !== {1'b0, 1'b0, 1'b0, 5'd31} || busy_out !== 1'b0 || done_out !== 1'b0)
            $display("FAIL midscan_reset got res=%h busy=%b done=%b want res=1f busy=0 done=0",
                     res, busy_out, done_out);
        else pass_cnt++;
        saw = 0;
        repeat (3) begin
            @(posedge clk_in);
            #1;
            if (done_out) saw = 1;
        end
        reset_in = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (i == 0) do_start(pack(sol));
            else begin
                @(posedge clk_in);
                #1;
            end
            if (i < 27 && done_out) saw = 1;
        end
        total_cnt++;
        if (saw) $display("FAIL midscan_no_done got pulse want none");
        else pass_cnt++;
        do_start(pack(sol));
        wait_done(0, cyc);
        total_cnt++;
        if (cyc != 28 || res !== model(sol))
            $display("FAIL midscan_restart got lat=%0d res=%h want lat=28 res=%h", cyc, res, model(sol));
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        grid_t g;
        int cyc;
        logic [7:0] exp;
        g = sol;
        g[3][0] = 7;
        exp = model(g);
        do_start(pack(g));
        wait_done(0, cyc);
        total_cnt++;
        if (cyc != 28 || res !== exp)
            $display("FAIL b2b_first got lat=%0d res=%h want lat=28 res=%h", cyc, res, exp);
        else pass_cnt++;
        exp = model(sol);
        do_start(pack(sol));
        total_cnt++;
        if (busy_out !== 1'b1 || res !== {1'b0, 1'b0, 1'b0, 5'd31})
            $display("FAIL b2b_accept got busy=%b res=%h want busy=1 res=1f", busy_out, res);
        else pass_cnt++;
        wait_done(0, cyc);
        total_cnt++;
        if (cyc != 28 || res !== exp)
            $display("FAIL b2b_second got lat=%0d res=%h want lat=28 res=%h", cyc, res, exp);
        else pass_cnt++;
    endtask

    initial begin
        sol = '{'{2, 5, 4, 8, 1, 3, 6, 9, 7},
                '{6, 9, 7, 5, 2, 4, 8, 3, 1},
                '{8, 1, 3, 7, 6, 9, 5, 2, 4},
                '{3, 6, 1, 9, 4, 5, 7, 8, 2},
                '{4, 7, 2, 1, 3, 8, 9, 5, 6},
                '{5, 8, 9, 6, 7, 2, 1, 4, 3},
                '{7, 3, 5, 2, 8, 1, 4, 6, 9},
                '{1, 2, 8, 4, 9, 6, 3, 7, 5},
                '{9, 4, 6, 3, 5, 7, 2, 1, 8}};
        test_reset();
        test_solved();
        test_corners();
        test_random();
        test_ignore_start();
        test_reset_midscan();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
